// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit: opcodes, ALU operations,
// datapath mux selects and the controller state enumeration.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_JALR     = 4'd11,
        S_JALR2    = 4'd12,
        S_LUI      = 4'd13,
        S_AUIPC    = 4'd14,
        S_TRAP     = 4'd15
    } state_e;

    // Branch decision from the ALU comparison flags; funct3 2/3 are not branches.
    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero,
                                          input logic lt, input logic ltu);
        logic taken;
        case (funct3)
            3'd0:    taken = zero;
            3'd1:    taken = ~zero;
            3'd4:    taken = lt;
            3'd5:    taken = ~lt;
            3'd6:    taken = ltu;
            3'd7:    taken = ~ltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3/funct7 to ALU operation map, shared by register-register and
// register-immediate execute states.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_imm,
    output logic [3:0] alu_op
);

    // funct7 only distinguishes SUB for register forms; SRA/SRAI both use it.
    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'd0: begin
                if (!is_imm && (funct7 == F7_ALT)) begin
                    alu_op = ALU_SUB;
                end else begin
                    alu_op = ALU_ADD;
                end
            end
            3'd1: alu_op = ALU_SLL;
            3'd2: alu_op = ALU_SLT;
            3'd3: alu_op = ALU_SLTU;
            3'd4: alu_op = ALU_XOR;
            3'd5: begin
                if (funct7 == F7_ALT) begin
                    alu_op = ALU_SRA;
                end else begin
                    alu_op = ALU_SRL;
                end
            end
            3'd6: alu_op = ALU_OR;
            3'd7: alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I controller: sequences fetch/decode/execute/memory/writeback
// over one shared ALU and one unified memory port.
module multicycle_control_fsm
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 4,
    parameter int MEM_HANDSHAKE = 1,
    parameter int TRAP_ENABLE   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [2:0]           imm_src,
    output logic [1:0]           result_src,
    output logic [ALUCTRL_W-1:0] alu_control,
    output logic                 illegal
);

    state_e     state_q;
    state_e     state_d;
    logic       ready_s;
    logic [3:0] dec_alu_s;
    logic [3:0] alu_s;
    logic       pc_write_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       reg_write_s;

    assign ready_s = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;

    alu_decoder u_alu_decoder (
        .funct3 (funct3),
        .funct7 (funct7),
        .is_imm (state_q == S_EXECI),
        .alu_op (dec_alu_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        state_d     = state_q;
        pc_write_s  = 1'b0;
        adr_src     = 1'b0;
        mem_read    = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        imm_src     = IMM_I;
        result_src  = RES_ALUOUT;
        alu_s       = ALU_ADD;
        illegal     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read   = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                if (ready_s) begin
                    pc_write_s = 1'b1;
                    ir_write_s = 1'b1;
                    state_d    = S_DECODE;
                end else begin
                    state_d    = S_FETCH;
                end
            end
            S_DECODE: begin
                // ALUOut captures OldPC+imm; JAL needs the J immediate for its target.
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECR;
                    OP_ITYPE:          state_d = S_EXECI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = (TRAP_ENABLE != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                if (op == OP_STORE) begin
                    imm_src = IMM_S;
                    state_d = S_MEMWRITE;
                end else begin
                    imm_src = IMM_I;
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                state_d  = ready_s ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                result_src  = RES_MEM;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
                state_d     = ready_s ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                alu_s     = dec_alu_s;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                // rs1 is the A operand for register-immediate ops.
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                alu_s     = dec_alu_s;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                result_src  = RES_ALUOUT;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                alu_s      = ALU_SUB;
                result_src = RES_ALUOUT;
                pc_write_s = branch_taken(funct3, zero, lt, ltu);
                state_d    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = SRCA_OLDPC;
                alu_src_b   = SRCB_FOUR;
                imm_src     = IMM_J;
                result_src  = RES_ALUOUT;
                pc_write_s  = 1'b1;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_JALR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_I;
                state_d   = S_JALR2;
            end
            S_JALR2: begin
                result_src  = RES_ALU;
                pc_write_s  = 1'b1;
                reg_write_s = 1'b1;
                state_d     = S_FETCH;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_U;
                state_d   = S_ALUWB;
            end
            S_TRAP: begin
                illegal = 1'b1;
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Writes are suppressed in the cycle reset is sampled so no state is corrupted.
    assign pc_write    = pc_write_s  & ~rst;
    assign mem_write   = mem_write_s & ~rst;
    assign ir_write    = ir_write_s  & ~rst;
    assign reg_write   = reg_write_s & ~rst;
    assign alu_control = ALUCTRL_W'(alu_s);

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench: per-instruction expected-cycle queues built from the ISA rules,
// directed corner sequences, and a table of single-instruction vectors.
module tb_multicycle_control_fsm;

    localparam logic [6:0] O_LOAD = 7'b0000011, O_STORE = 7'b0100011, O_R = 7'b0110011;
    localparam logic [6:0] O_I = 7'b0010011, O_BR = 7'b1100011, O_JAL = 7'b1101111;
    localparam logic [6:0] O_JALR = 7'b1100111, O_LUI = 7'b0110111, O_AUIPC = 7'b0010111;
    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_SLL = 4'd4;
    localparam logic [3:0] A_SRL = 4'd5, A_SRA = 4'd6, A_XOR = 4'd7, A_SLT = 4'd8, A_SLTU = 4'd9;
    localparam logic [2:0] I_I = 3'd0, I_S = 3'd1, I_B = 3'd2, I_J = 3'd3, I_U = 3'd4;

    logic clk = 1'b0;
    logic rst, zero, lt, ltu, mem_ready;
    logic [6:0] op, funct7;
    logic [2:0] funct3;
    logic pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src;
    logic [3:0] alu_control;
    logic n_pc_write, n_adr_src, n_mem_read, n_mem_write, n_ir_write, n_reg_write, n_illegal;
    logic [1:0] n_alu_src_a, n_alu_src_b, n_result_src;
    logic [2:0] n_imm_src;
    logic [3:0] n_alu_control;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .pc_write(pc_write), .adr_src(adr_src),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_src(imm_src), .result_src(result_src), .alu_control(alu_control),
        .illegal(illegal)
    );

    multicycle_control_fsm #(.TRAP_ENABLE(0)) dut_nt (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .pc_write(n_pc_write),
        .adr_src(n_adr_src), .mem_read(n_mem_read), .mem_write(n_mem_write),
        .ir_write(n_ir_write), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
        .alu_src_b(n_alu_src_b), .imm_src(n_imm_src), .result_src(n_result_src),
        .alu_control(n_alu_control), .illegal(n_illegal)
    );

    typedef struct packed {
        logic       pcw, adr, mrd, mwr, irw, rw;
        logic [1:0] sa, sb;
        logic [2:0] imm;
        logic [1:0] res;
        logic [3:0] alu;
        logic       ill;
    } outv_t;

    typedef struct {
        logic  rdy;
        outv_t o;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       z, l, lu;
        int         cpi;
        logic [3:0] alu3;
        logic       pcw_last, rw_last;
    } vec_t;

    cyc_t q[$];
    vec_t tbl [17];
    logic [6:0] ops [9] = '{O_LOAD, O_STORE, O_R, O_I, O_BR, O_JAL, O_JALR, O_LUI, O_AUIPC};

    function automatic outv_t mk(logic pcw, logic adr, logic mrd, logic mwr, logic irw,
                                 logic rw, logic [1:0] sa, logic [1:0] sb, logic [2:0] imm,
                                 logic [1:0] res, logic [3:0] alu, logic ill);
        outv_t v;
        v.pcw = pcw; v.adr = adr; v.mrd = mrd; v.mwr = mwr; v.irw = irw; v.rw = rw;
        v.sa = sa; v.sb = sb; v.imm = imm; v.res = res; v.alu = alu; v.ill = ill;
        return v;
    endfunction

    function automatic outv_t got_main();
        return mk(pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, alu_src_a,
                  alu_src_b, imm_src, result_src, alu_control, illegal);
    endfunction

    function automatic outv_t got_nt();
        return mk(n_pc_write, n_adr_src, n_mem_read, n_mem_write, n_ir_write, n_reg_write,
                  n_alu_src_a, n_alu_src_b, n_imm_src, n_result_src, n_alu_control, n_illegal);
    endfunction

    function automatic outv_t fetch_o(logic done);
        return mk(done, 1'b0, 1'b1, 1'b0, done, 1'b0, 2'b00, 2'b10, I_I, 2'b10, A_ADD, 1'b0);
    endfunction

    function automatic outv_t decode_o(logic [6:0] o);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01,
                  (o == O_JAL) ? I_J : I_B, 2'b00, A_ADD, 1'b0);
    endfunction

    function automatic outv_t trap_o();
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, I_I, 2'b00, A_ADD, 1'b1);
    endfunction

    function automatic outv_t wb_o(logic [1:0] res, logic pcw);
        return mk(pcw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, I_I, res, A_ADD, 1'b0);
    endfunction

    // RV32I operation named by funct3, with the funct7 alternates.
    function automatic logic [3:0] alu_ref(logic [2:0] f3, logic [6:0] f7, logic is_imm);
        logic [3:0] tab [0:7];
        tab = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        if (f3 == 3'd0 && !is_imm && f7 == 7'h20) return A_SUB;
        if (f3 == 3'd5 && f7 == 7'h20) return A_SRA;
        return tab[f3];
    endfunction

    function automatic logic taken_ref(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return !($signed(a) < $signed(b));
            3'd6:    return a < b;
            3'd7:    return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Expected per-cycle outputs for one instruction, including chosen wait cycles.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic bt, input int wf, input int wm);
        outv_t m;
        for (int i = 0; i < wf; i++) q.push_back('{1'b0, fetch_o(1'b0)});
        q.push_back('{1'b1, fetch_o(1'b1)});
        q.push_back('{rb(), decode_o(o)});
        case (o)
            O_LOAD, O_STORE: begin
                q.push_back('{rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
                                      (o == O_STORE) ? I_S : I_I, 2'b00, A_ADD, 1'b0)});
                m = mk(1'b0, 1'b1, (o == O_LOAD), (o == O_STORE), 1'b0, 1'b0, 2'b00, 2'b00,
                       I_I, 2'b00, A_ADD, 1'b0);
                for (int i = 0; i < wm; i++) q.push_back('{1'b0, m});
                q.push_back('{1'b1, m});
                if (o == O_LOAD) q.push_back('{rb(), wb_o(2'b01, 1'b0)});
            end
            O_R, O_I: begin
                q.push_back('{rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10,
                                      (o == O_I) ? 2'b01 : 2'b00, I_I, 2'b00,
                                      alu_ref(f3, f7, (o == O_I)), 1'b0)});
                q.push_back('{rb(), wb_o(2'b00, 1'b0)});
            end
            O_BR: q.push_back('{rb(), mk(bt, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00,
                                        I_I, 2'b00, A_SUB, 1'b0)});
            O_JAL: q.push_back('{rb(), mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b10,
                                         I_J, 2'b00, A_ADD, 1'b0)});
            O_JALR: begin
                q.push_back('{rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01,
                                      I_I, 2'b00, A_ADD, 1'b0)});
                q.push_back('{rb(), wb_o(2'b10, 1'b1)});
            end
            O_LUI, O_AUIPC: begin
                q.push_back('{rb(), mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                      (o == O_LUI) ? 2'b11 : 2'b01, 2'b01, I_U, 2'b00,
                                      A_ADD, 1'b0)});
                q.push_back('{rb(), wb_o(2'b00, 1'b0)});
            end
            default: ;
        endcase
    endtask

    task automatic run_q(input string tag);
        cyc_t c;
        int n;
        n = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            mem_ready = c.rdy;
            @(negedge clk);
            chk($sformatf("%s_c%0d", tag, n), 32'(got_main()), 32'(c.o));
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [3:0]  alu3;
        logic        lp, lr, found;
        int          cyc;

        tbl[0]  = '{O_R,     3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b0, 1'b1};
        tbl[1]  = '{O_R,     3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 4, A_SUB,  1'b0, 1'b1};
        tbl[2]  = '{O_R,     3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 4, A_SRA,  1'b0, 1'b1};
        tbl[3]  = '{O_R,     3'd3, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_SLTU, 1'b0, 1'b1};
        tbl[4]  = '{O_I,     3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 4, A_SRA,  1'b0, 1'b1};
        tbl[5]  = '{O_I,     3'd0, 7'h20, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b0, 1'b1};
        tbl[6]  = '{O_I,     3'd5, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_SRL,  1'b0, 1'b1};
        tbl[7]  = '{O_BR,    3'd1, 7'h00, 1'b0, 1'b0, 1'b0, 3, A_SUB,  1'b1, 1'b0};
        tbl[8]  = '{O_BR,    3'd1, 7'h00, 1'b1, 1'b0, 1'b0, 3, A_SUB,  1'b0, 1'b0};
        tbl[9]  = '{O_BR,    3'd7, 7'h00, 1'b0, 1'b0, 1'b1, 3, A_SUB,  1'b0, 1'b0};
        tbl[10] = '{O_BR,    3'd2, 7'h00, 1'b1, 1'b1, 1'b1, 3, A_SUB,  1'b0, 1'b0};
        tbl[11] = '{O_LOAD,  3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 5, A_ADD,  1'b0, 1'b1};
        tbl[12] = '{O_STORE, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b0, 1'b0};
        tbl[13] = '{O_JAL,   3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 3, A_ADD,  1'b1, 1'b1};
        tbl[14] = '{O_JALR,  3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b1, 1'b1};
        tbl[15] = '{O_LUI,   3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b0, 1'b1};
        tbl[16] = '{O_AUIPC, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 4, A_ADD,  1'b0, 1'b1};

        rst = 1'b1; mem_ready = 1'b1; op = O_R; funct3 = 3'd0; funct7 = 7'h00;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;

        // Reset: FETCH reached, write strobes held low while rst is high.
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_gate", 32'({pc_write, ir_write, reg_write, mem_write}), 32'd0);
        chk("rst_fetch_read", 32'(mem_read), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("reset_state", 32'(got_main()), 32'(fetch_o(1'b0)));
        @(posedge clk); #1;

        // Illegal opcode: TRAP held; TRAP_ENABLE=0 instance goes back to FETCH.
        op = 7'h7f; mem_ready = 1'b1;
        @(negedge clk);
        chk("trap_fetch", 32'(got_main()), 32'(fetch_o(1'b1)));
        chk("nt_fetch", 32'(got_nt()), 32'(fetch_o(1'b1)));
        @(posedge clk); #1;
        @(negedge clk);
        chk("trap_decode", 32'(got_main()), 32'(decode_o(7'h7f)));
        chk("nt_decode", 32'(got_nt()), 32'(decode_o(7'h7f)));
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = rb();
            @(negedge clk);
            chk($sformatf("trap_hold_%0d", i), 32'(got_main()), 32'(trap_o()));
            if (i == 0) chk("nt_refetch", 32'(got_nt()), 32'(fetch_o(mem_ready)));
            @(posedge clk); #1;
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("trap_in_rst", 32'(got_main()), 32'(trap_o()));
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("trap_exit", 32'(got_main()), 32'(fetch_o(1'b0)));
        chk("nt_exit", 32'(got_nt()), 32'(fetch_o(1'b0)));
        @(posedge clk); #1;

        // lw with two MEMREAD wait cycles: 7 cycles total.
        op = O_LOAD; funct3 = 3'd2;
        build(O_LOAD, 3'd2, 7'h00, 1'b0, 0, 2);
        run_q("lw_wait");

        // Randomized instruction stream against the queue model.
        for (int k = 0; k < 80; k++) begin
            op = ops[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 2))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            a = $urandom;
            b = rb() ? a : $urandom;
            funct3 = f3; funct7 = f7;
            zero = (a - b) == 32'd0;
            lt = $signed(a) < $signed(b);
            ltu = a < b;
            build(op, f3, f7, taken_ref(f3, a, b), $urandom_range(0, 2), $urandom_range(0, 2));
            run_q($sformatf("rnd%0d", k));
        end

        // Reset during a stalled store.
        op = O_STORE; funct3 = 3'd2;
        q.push_back('{1'b1, fetch_o(1'b1)});
        q.push_back('{1'b1, decode_o(O_STORE)});
        q.push_back('{1'b1, mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, I_S, 2'b00,
                              A_ADD, 1'b0)});
        q.push_back('{1'b0, mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, I_I, 2'b00,
                              A_ADD, 1'b0)});
        run_q("sw_stall");
        rst = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_mw_gate", 32'({mem_write, pc_write, reg_write, ir_write}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mw_fetch", 32'(got_main()), 32'(fetch_o(1'b0)));
        @(posedge clk); #1;

        // Table of single instructions, mem_ready high; each starts at a FETCH negedge.
        mem_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            op = tbl[i].op; funct3 = tbl[i].f3; funct7 = tbl[i].f7;
            zero = tbl[i].z; lt = tbl[i].l; ltu = tbl[i].lu;
            chk($sformatf("tbl%0d_fetch", i), 32'(ir_write), 32'd1);
            cyc = 1; alu3 = 4'hf; lp = 1'b0; lr = 1'b0; found = 1'b0;
            for (int g = 0; g < 12; g++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (ir_write) begin
                    found = 1'b1;
                    break;
                end
                cyc++;
                if (cyc == 3) alu3 = alu_control;
                lp = pc_write;
                lr = reg_write;
            end
            chk($sformatf("tbl%0d_refetch", i), 32'(found), 32'd1);
            chk($sformatf("tbl%0d_cpi", i), 32'(cyc), 32'(tbl[i].cpi));
            chk($sformatf("tbl%0d_alu", i), 32'(alu3), 32'(tbl[i].alu3));
            chk($sformatf("tbl%0d_pcw", i), 32'(lp), 32'(tbl[i].pcw_last));
            chk($sformatf("tbl%0d_rw", i), 32'(lr), 32'(tbl[i].rw_last));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Multi-cycle RV32I control unit that replaces the single-cycle combinational decoder with a state machine. It sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one unified memory port. It adds full branch-condition support, SRA/SLTU, LUI/AUIPC, a memory-ready wait handshake and illegal-opcode trapping. It sits between the instruction register and the datapath muxes, register-file write enable and memory enables.

Parameters:
ALUCTRL_W, 4, width of alu_control; the encodings below occupy the low 4 bits and upper bits are zero.
MEM_HANDSHAKE, 1, 1 = memory states wait for mem_ready; 0 = mem_ready ignored and memory is treated as ready every cycle.
TRAP_ENABLE, 1, 1 = unknown opcode enters TRAP; 0 = unknown opcode is treated as a NOP and returns to FETCH.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
op  in  7  instruction opcode from the IR
funct3  in  3  instruction funct3
funct7  in  7  instruction funct7
zero  in  1  ALU result == 0
lt  in  1  signed rs1 < rs2
ltu  in  1  unsigned rs1 < rs2
mem_ready  in  1  memory access completes this cycle
pc_write  out  1  PC register load
adr_src  out  1  0 = PC, 1 = ALUOut to memory address
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load (also latches OldPC)
reg_write  out  1  register-file write enable
alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
alu_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
imm_src  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
result_src  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result
alu_control  out  ALUCTRL_W  ALU operation
illegal  out  1  high while in TRAP

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. On reset the state is FETCH; there are no other registers.
- Outputs are decoded combinationally from the state (and from op/funct fields where stated). In the cycle after reset the FETCH outputs appear.
- ALU encoding: ADD 0000, SUB 0001, AND 0010, OR 0011, SLL 0100, SRL 0101, SRA 0110, XOR 0111, SLT 1000, SLTU 1001.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, TRAP.
- FETCH: adr_src=0, mem_read=1, alu_src_a=00, alu_src_b=10, ADD, result_src=10.
  - pc_write and ir_write are asserted only when the access completes (mem_ready, or unconditionally when MEM_HANDSHAKE=0).
  - The FSM stays in FETCH until then, with no other side effects.
- DECODE: alu_src_a=01, alu_src_b=01, imm_src=B, ADD (precomputes the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - 0110111 -> LUI
  - 0010111 -> AUIPC
  - anything else -> TRAP, or FETCH when TRAP_ENABLE=0
- MEMADR: alu_src_a=10, alu_src_b=01, ADD; imm_src=I for loads, S for stores. Next state MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: adr_src=1, mem_read=1. Advances to MEMWB on completion, otherwise holds.
- MEMWB: result_src=01, reg_write=1. Next FETCH.
- MEMWRITE: adr_src=1, mem_write=1. mem_write stays asserted every waiting cycle. Next FETCH on completion.
- EXECR: alu_src_a=10, alu_src_b=00.
  - funct3 0: SUB if funct7==0100000, else ADD.
  - funct3 1: SLL. 2: SLT. 3: SLTU. 4: XOR. 6: OR. 7: AND.
  - funct3 5: SRA if funct7==0100000, else SRL.
  - Next state ALUWB.
- EXECI: alu_src_b=01, imm_src=I, same funct3 map as EXECR. funct3 0 is always ADD. funct3 5 selects SRA only when funct7==0100000. Next ALUWB.
- ALUWB: result_src=00, reg_write=1. Next FETCH.
- BRANCH: alu_src_a=10, alu_src_b=00, SUB, result_src=00.
  - pc_write = taken, where taken is: beq zero; bne !zero; blt lt; bge !lt; bltu ltu; bgeu !ltu.
  - funct3 2 or 3 gives taken=0.
  - Next FETCH.
- JAL: alu_src_a=01, alu_src_b=10, ADD, result_src=00, pc_write=1, reg_write=1. Next FETCH.
  - The target is ALUOut from DECODE with imm_src held at J. Because DECODE already used B, the J immediate is presented in DECODE whenever op==JAL.
- JALR, two cycles:
  - Cycle 1: alu_src_a=10, alu_src_b=01, imm_src=I, ADD.
  - Cycle 2 (ALUWB-like sub-state JALR2): result_src=10 drives the target to the PC, pc_write=1; rd<=OldPC+4 comes from the datapath.
  - Next FETCH.
- LUI: alu_src_a=11, alu_src_b=01, imm_src=U, ADD. Next ALUWB.
- AUIPC: alu_src_a=01, alu_src_b=01, imm_src=U, ADD. Next ALUWB.
- TRAP: illegal=1, and every enable is 0. Held until rst.
- Defaults: every output not listed for a state is 0.
- Reset mid-operation: any state returns to FETCH in the cycle after rst is sampled, with no write strobes asserted on the reset edge cycle.

Decomposition:
- Shared package rv_ctrl_pkg holds:
  - opcode localparams
  - ALU encodings
  - imm_src, result_src and alu_src encodings
  - the state enumeration
- One sub-module, alu_decoder, is natural: combinational funct3/funct7/opclass -> alu_control, reused by EXECR and EXECI.

Test Plan:
- add x3,x1,x2 with mem_ready=1 -> states FETCH, DECODE, EXECR, ALUWB; alu_control=0000; reg_write high in cycle 4 only; CPI 4.
- lw with mem_ready low for 2 cycles in MEMREAD -> MEMREAD persists 3 cycles, no reg_write until MEMWB; total 7 cycles.
- bne with zero=0 -> pc_write=1 in BRANCH. Same instruction with zero=1 -> pc_write=0. bgeu with ltu=1 -> not taken.
- sub (funct7=0100000, funct3=0) -> 0001; sra -> 0110; srai -> 0110; sltu -> 1001.
- op=1111111 -> TRAP with illegal=1 held 10 cycles; rst pulse -> FETCH next cycle. With TRAP_ENABLE=0 -> FETCH after DECODE.
- rst asserted during MEMWRITE with mem_ready=0 -> next state FETCH, mem_write=0 from that cycle onward.
